// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM driver: channel count, default PWM width and the RGB channel map.
// Channel i drives bit i of the frame; each RGB LED owns three consecutive channels (R, G, B).
package led_pwm_pkg;

    localparam int NUM_CH           = 12;
    localparam int NUM_LED          = 4;
    localparam int PWM_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } led_color_e;

    localparam int LED0_R = 0;
    localparam int LED0_G = 1;
    localparam int LED0_B = 2;
    localparam int LED1_R = 3;
    localparam int LED1_G = 4;
    localparam int LED1_B = 5;
    localparam int LED2_R = 6;
    localparam int LED2_G = 7;
    localparam int LED2_B = 8;
    localparam int LED3_R = 9;
    localparam int LED3_G = 10;
    localparam int LED3_B = 11;

    function automatic int ch_idx(input int led, input led_color_e col);
        return led * 3 + int'(col);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM output channel: level register, optional fade step, duty compare and registered active-low drive.
// Fade stepping is compiled in only when LED_PWM_FADE_EN is defined; otherwise the level loads the target directly.
module led_pwm_channel
#(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boundary,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_n
);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nxt;
    logic                on_p0;

`ifdef LED_PWM_FADE_EN
    localparam logic [PWM_BITS-1:0] LVL_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    function automatic logic [PWM_BITS-1:0] fade_step(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
        if (cur < tgt)
            return cur + LVL_ONE;
        else if (cur > tgt)
            return cur - LVL_ONE;
        return cur;
    endfunction

    assign level_nxt = fade_step(level, target);
`else
    assign level_nxt = target;
`endif

    // compare stage: level 0 never lights, the top count value never lights
    assign on_p0 = (pwm_cnt < level);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            led_n <= 1'b1;
        end else begin
            if (boundary)
                level <= level_nxt;
            led_n <= ~on_p0;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// 12-channel LED PWM driver: prescaler, PWM counter, double-buffered frame handshake, one channel per bit.
// Define LED_PWM_FADE_EN to make each channel level ramp by one step per period instead of jumping.
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = 64,
    parameter int PWM_BITS     = PWM_BITS_DEFAULT
) (
    input  logic                _i_clk,
    input  logic                _i_rst,
    input  logic [NUM_CH-1:0]   _i_frame,
    input  logic                _i_frame_valid,
    output logic                _o_frame_ready,
    input  logic [PWM_BITS-1:0] _i_brightness,
    output logic [NUM_CH-1:0]   _o_led_n,
    output logic                _o_period_start
);

    localparam logic [15:0]         PRESC_LAST = 16'(PRESCALE_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_ONE    = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [15:0]         presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                presc_wrap;
    logic                boundary;

    logic                pending_full;
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   active;
    logic [NUM_CH-1:0]   frame_nxt;
    logic [PWM_BITS-1:0] bright_q;
    logic                accept;

    function automatic logic [PWM_BITS-1:0] gate_level(input logic                bit_on,
                                                       input logic [PWM_BITS-1:0] bright);
        return bit_on ? bright : '0;
    endfunction

    assign presc_wrap     = (presc == PRESC_LAST);
    assign boundary       = presc_wrap && (pwm_cnt == '1);
    assign _o_frame_ready = ~pending_full & ~_i_rst;
    assign accept         = _i_frame_valid & ~pending_full;
    assign frame_nxt      = pending_full ? pending : active;

    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            presc           <= '0;
            pwm_cnt         <= '0;
            _o_period_start <= 1'b0;
        end else begin
            presc           <= presc_wrap ? 16'd0 : presc + 16'd1;
            if (presc_wrap)
                pwm_cnt <= pwm_cnt + CNT_ONE;
            _o_period_start <= boundary;
        end
    end

    // accept and transfer are exclusive: accept needs an empty buffer, transfer a full one
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            pending_full <= 1'b0;
            active       <= '0;
            bright_q     <= '0;
        end else begin
            if (boundary) begin
                active   <= frame_nxt;
                bright_q <= _i_brightness;
            end
            if (boundary && pending_full)
                pending_full <= 1'b0;
            else if (accept)
                pending_full <= 1'b1;
        end
    end

    always_ff @(posedge _i_clk) begin
        if (accept && !_i_rst)
            pending <= _i_frame;
    end

    // at a boundary the channels load the image and brightness that govern the coming period
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PWM_BITS-1:0] tgt;

        assign tgt = boundary ? gate_level(frame_nxt[gi], _i_brightness)
                              : gate_level(active[gi], bright_q);

        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk      (_i_clk),
            .rst      (_i_rst),
            .boundary (boundary),
            .target   (tgt),
            .pwm_cnt  (pwm_cnt),
            .led_n    (_o_led_n[gi])
        );
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver (PRESCALE_DIV=2, PWM_BITS=4): period-level reference model plus directed scenarios.
module tb_led_pwm_driver;

    logic        clk;
    logic        rst;
    logic [11:0] frame;
    logic        valid;
    logic        ready;
    logic [3:0]  bright;
    logic [11:0] led_n;
    logic        ps;

    int vecs = 0;
    int errs = 0;
    int lowcnt [12];

    led_pwm_driver #(
        .PRESCALE_DIV (2),
        .PWM_BITS     (4)
    ) dut (
        ._i_clk          (clk),
        ._i_rst          (rst),
        ._i_frame        (frame),
        ._i_frame_valid  (valid),
        ._o_frame_ready  (ready),
        ._i_brightness   (bright),
        ._o_led_n        (led_n),
        ._o_period_start (ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycle index since reset release, 32 cycles per period, count = (index mod 32) / 2.
    bit          mvalid = 1'b0;
    int          cur;
    bit          m_pf;
    logic [11:0] m_pend;
    logic [11:0] m_act;
    int          m_lvl [12];
    logic [11:0] exp_led;
    logic        exp_ps;
    int          m_cnt;
    int          m_tgt;
    bit          m_bnd;
    bit          m_acc;

    always @(posedge clk) begin
        if (rst) begin
            mvalid  = 1'b1;
            cur     = 0;
            m_pf    = 1'b0;
            m_pend  = '0;
            m_act   = '0;
            for (int i = 0; i < 12; i++) m_lvl[i] = 0;
            exp_led = 12'hFFF;
            exp_ps  = 1'b0;
        end else if (mvalid) begin
            m_cnt = (cur % 32) / 2;
            for (int i = 0; i < 12; i++) exp_led[i] = !(m_cnt < m_lvl[i]);
            m_bnd  = ((cur % 32) == 31);
            exp_ps = m_bnd;
            m_acc  = valid && !m_pf;
            if (m_bnd) begin
                if (m_pf) begin
                    m_act = m_pend;
                    m_pf  = 1'b0;
                end
                for (int i = 0; i < 12; i++) begin
                    m_tgt = m_act[i] ? int'(bright) : 0;
`ifdef LED_PWM_FADE_EN
                    if (m_lvl[i] < m_tgt) m_lvl[i] = m_lvl[i] + 1;
                    else if (m_lvl[i] > m_tgt) m_lvl[i] = m_lvl[i] - 1;
`else
                    m_lvl[i] = m_tgt;
`endif
                end
            end
            if (m_acc) begin
                m_pend = frame;
                m_pf   = 1'b1;
            end
            cur++;
        end
    end

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            check("led_n", led_n, exp_led);
            check("period_start", {11'd0, ps}, {11'd0, exp_ps});
            check("frame_ready", {11'd0, ready}, {11'd0, (!m_pf && !rst)});
        end
    end

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (ps) ok = 1'b1;
        end
        if (!ok) begin
            vecs++;
            errs++;
            $display("FAIL period_start_timeout: got no pulse, required one within 64 cycles");
        end
    endtask

    // counts low cycles per channel over one full period, starting at the period_start cycle
    task automatic count_period(input int chg_at, input logic [3:0] nb);
        bit ok;
        for (int i = 0; i < 12; i++) lowcnt[i] = 0;
        wait_ps(ok);
        if (!ok) return;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) @(negedge clk);
            for (int i = 0; i < 12; i++)
                if (led_n[i] == 1'b0) lowcnt[i]++;
            if (j == chg_at) bright = nb;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        frame  = '0;
        bright = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {11'd0, ready}, 12'd0);
        check("rst_led_n", led_n, 12'hFFF);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {11'd0, ready}, 12'd1);
        check("post_rst_led_n", led_n, 12'hFFF);

`ifdef LED_PWM_FADE_EN
        #1 begin valid = 1'b1; frame = 12'hFFF; bright = 4'd15; end
        @(negedge clk);
        #1 valid = 1'b0;
        for (int p = 1; p <= 15; p++) begin
            count_period(-1, 4'd0);
            check_int("fade_low_ch0", lowcnt[0], 2 * p);
            check_int("fade_low_ch11", lowcnt[11], 2 * p);
        end
        count_period(-1, 4'd0);
        check_int("fade_hold_ch5", lowcnt[5], 30);
`else
        #1 begin valid = 1'b1; frame = 12'h001; bright = 4'd8; end
        @(negedge clk);
        check("pending_ready", {11'd0, ready}, 12'd0);
        #1 frame = 12'h0F0;
        @(negedge clk);
        check("dropped_ready", {11'd0, ready}, 12'd0);
        #1 begin valid = 1'b0; frame = '0; end

        count_period(-1, 4'd0);
        check_int("b8_low_ch0", lowcnt[0], 16);
        check_int("b8_low_ch1", lowcnt[1], 0);
        check_int("dropped_low_ch4", lowcnt[4], 0);
        check("ready_after_xfer", {11'd0, ready}, 12'd1);

        count_period(10, 4'd4);
        check_int("midchange_low_ch0", lowcnt[0], 16);
        count_period(-1, 4'd0);
        check_int("b4_low_ch0", lowcnt[0], 8);

        #1 begin valid = 1'b1; frame = 12'h0FF; end
        @(negedge clk);
        #1 valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midperiod_led_n", led_n, 12'hFFE);
        check("midperiod_ready", {11'd0, ready}, 12'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_led_n", led_n, 12'hFFF);
        check("midrst_ready", {11'd0, ready}, 12'd0);
        #1 rst = 1'b0;
        count_period(-1, 4'd0);
        check_int("after_rst_low_ch0", lowcnt[0], 0);
        check_int("after_rst_low_ch7", lowcnt[7], 0);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
